// File: rtl/bnn_byte_loader_pkg.sv
// -----------------------------------------------------------------------------
// bnn_pkg
//   Shared definitions for the BNN input loader: section byte counts, the
//   loader FSM state type and a small state-classification helper.
// -----------------------------------------------------------------------------
package bnn_pkg;

  // Bytes per section of the model image.
  localparam int unsigned PIX_BYTES = 98;
  localparam int unsigned W1_BYTES  = 9;
  localparam int unsigned W2_BYTES  = 36;
  localparam int unsigned W3_BYTES  = 245;

  localparam int unsigned FULL_LOAD_BYTES = PIX_BYTES + W1_BYTES + W2_BYTES + W3_BYTES;

  // Loader FSM states. ST_CHK is only reachable when the checksum feature
  // is built in; the encoding is kept identical in both builds.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PIX  = 3'd1,
    ST_W1   = 3'd2,
    ST_W2   = 3'd3,
    ST_W3   = 3'd4,
    ST_CHK  = 3'd5,
    ST_DONE = 3'd6
  } load_state_t;

  // States in which strobed bytes are accepted.
  function automatic logic is_loading(input load_state_t s);
    return (s == ST_PIX) || (s == ST_W1) || (s == ST_W2) ||
           (s == ST_W3)  || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/bnn_byte_loader_if.sv
// -----------------------------------------------------------------------------
// bnn_byte_loader_if
//   Bus between the chip-pin host side and the byte loader.
//   master : drives start / pixels_only / data_in / data_strobe,
//            observes the assembled vectors and status.
//   slave  : the loader itself.
//   Signals:
//     start        1-cycle pulse, begins a load
//     pixels_only  sampled with start; 1 = reload pixels only
//     data_in      byte from pins (asynchronous to clk)
//     data_strobe  pin strobe, one byte per rising edge
//     pixels, weights1..3  assembled vectors
//     load_done    high while loaded
//     busy         high while a load is in progress
//     byte_idx     byte index within the current section
//     error        sticky checksum mismatch (0 unless checksum is built in)
// -----------------------------------------------------------------------------
interface bnn_byte_loader_if
  import bnn_pkg::*;
#(
  parameter int unsigned PIX_BITS = PIX_BYTES * 8,
  parameter int unsigned W1_BITS  = W1_BYTES * 8,
  parameter int unsigned W2_BITS  = W2_BYTES * 8,
  parameter int unsigned W3_BITS  = W3_BYTES * 8
);

  logic                start;
  logic                pixels_only;
  logic [7:0]          data_in;
  logic                data_strobe;
  logic [PIX_BITS-1:0] pixels;
  logic [W1_BITS-1:0]  weights1;
  logic [W2_BITS-1:0]  weights2;
  logic [W3_BITS-1:0]  weights3;
  logic                load_done;
  logic                busy;
  logic [8:0]          byte_idx;
  logic                error;

  modport master (
    output start, pixels_only, data_in, data_strobe,
    input  pixels, weights1, weights2, weights3,
    input  load_done, busy, byte_idx, error
  );

  modport slave (
    input  start, pixels_only, data_in, data_strobe,
    output pixels, weights1, weights2, weights3,
    output load_done, busy, byte_idx, error
  );

endinterface

// File: rtl/bnn_byte_loader_pin_sync_edge.sv
// -----------------------------------------------------------------------------
// pin_sync_edge
//   Two-flop synchroniser for an asynchronous pin followed by an edge
//   register. 'rise' is a one-cycle pulse valid in the cycle after the
//   synchronised level first goes high, so a pin first sampled high at
//   edge N is consumed by downstream logic at edge N+2.
//   Ports: clk, rst (async, active-high), d (async pin), rise (pulse).
// -----------------------------------------------------------------------------
module pin_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/bnn_byte_loader.sv
// -----------------------------------------------------------------------------
// bnn_byte_loader
//   Byte-wide loader that assembles the pixel image and the three binary
//   weight vectors from strobed pin bytes, then raises load_done to release
//   layer 1. Supports pixel-only reloads that keep the stored weights.
//
//   Ports:
//     clk  system clock
//     rst  asynchronous, active-high reset
//     bus  bnn_byte_loader_if.slave (start, pixels_only, data_in,
//          data_strobe in; pixels, weights1..3, load_done, busy,
//          byte_idx, error out)
//
//   Byte k of a section lands in bits [8k+7:8k] of that section's vector,
//   data_in[0] at the lowest index. Sections are loaded PIX, W1, W2, W3
//   (PIX only for a pixel reload). start always restarts at PIX/byte 0 and
//   wins over a byte accepted in the same cycle. Storage is cleared only
//   by rst.
//
//   Optional feature (macro BNN_LOADER_CHECKSUM_EN): a running XOR of all
//   accepted bytes is compared against one extra byte taken in ST_CHK;
//   a mismatch sets the sticky error flag. Without the macro there is no
//   ST_CHK and error is tied low.
// -----------------------------------------------------------------------------
module bnn_byte_loader
  import bnn_pkg::*;
#(
  parameter int unsigned PIX_BITS = PIX_BYTES * 8,
  parameter int unsigned W1_BITS  = W1_BYTES * 8,
  parameter int unsigned W2_BITS  = W2_BYTES * 8,
  parameter int unsigned W3_BITS  = W3_BYTES * 8
) (
  input  logic              clk,
  input  logic              rst,
  bnn_byte_loader_if.slave  bus
);

  localparam int unsigned PIX_N = PIX_BITS / 8;
  localparam int unsigned W1_N  = W1_BITS / 8;
  localparam int unsigned W2_N  = W2_BITS / 8;
  localparam int unsigned W3_N  = W3_BITS / 8;

  localparam logic [8:0] PIX_LAST = 9'(PIX_N - 1);
  localparam logic [8:0] W1_LAST  = 9'(W1_N - 1);
  localparam logic [8:0] W2_LAST  = 9'(W2_N - 1);
  localparam logic [8:0] W3_LAST  = 9'(W3_N - 1);

  // State entered after the final data section.
`ifdef BNN_LOADER_CHECKSUM_EN
  localparam load_state_t ST_FINAL = ST_CHK;
`else
  localparam load_state_t ST_FINAL = ST_DONE;
`endif

  load_state_t         state;
  logic [8:0]          byte_idx_q;
  logic                pix_only_q;
  logic                busy_q;
  logic                load_done_q;

  logic [PIX_BITS-1:0] pixels_q;
  logic [W1_BITS-1:0]  weights1_q;
  logic [W2_BITS-1:0]  weights2_q;
  logic [W3_BITS-1:0]  weights3_q;

  logic                byte_rise;
  logic                byte_ok;
  logic                sec_last;
  load_state_t         sec_next;

`ifdef BNN_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q;
  logic                error_q;
`endif

  // ---------------------------------------------------------------------------
  // Strobe synchroniser
  // ---------------------------------------------------------------------------
  pin_sync_edge u_strobe_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.data_strobe),
    .rise (byte_rise)
  );

  // A byte is taken only while loading, and never in a start cycle.
  assign byte_ok = byte_rise & is_loading(state) & ~bus.start;

  // ---------------------------------------------------------------------------
  // Section bookkeeping: is this the last byte, and where do we go next
  // ---------------------------------------------------------------------------
  always_comb begin
    sec_last = 1'b0;
    sec_next = state;
    case (state)
      ST_PIX: begin
        sec_last = (byte_idx_q == PIX_LAST);
        sec_next = pix_only_q ? ST_FINAL : ST_W1;
      end
      ST_W1: begin
        sec_last = (byte_idx_q == W1_LAST);
        sec_next = ST_W2;
      end
      ST_W2: begin
        sec_last = (byte_idx_q == W2_LAST);
        sec_next = ST_W3;
      end
      ST_W3: begin
        sec_last = (byte_idx_q == W3_LAST);
        sec_next = ST_FINAL;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Loader FSM with registered status outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      byte_idx_q  <= '0;
      pix_only_q  <= 1'b0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
`ifdef BNN_LOADER_CHECKSUM_EN
      csum_q      <= '0;
      error_q     <= 1'b0;
`endif
    end else if (bus.start) begin
      state       <= ST_PIX;
      byte_idx_q  <= '0;
      pix_only_q  <= bus.pixels_only;
      busy_q      <= 1'b1;
      load_done_q <= 1'b0;
`ifdef BNN_LOADER_CHECKSUM_EN
      csum_q      <= '0;
      error_q     <= 1'b0;
`endif
    end else if (byte_ok) begin
`ifdef BNN_LOADER_CHECKSUM_EN
      if (state == ST_CHK) begin
        error_q     <= (bus.data_in != csum_q);
        state       <= ST_DONE;
        busy_q      <= 1'b0;
        load_done_q <= 1'b1;
      end else begin
        csum_q <= csum_q ^ bus.data_in;
        if (sec_last) begin
          byte_idx_q <= '0;
          state      <= sec_next;
        end else begin
          byte_idx_q <= byte_idx_q + 9'd1;
        end
      end
`else
      if (sec_last) begin
        byte_idx_q <= '0;
        state      <= sec_next;
        if (sec_next == ST_DONE) begin
          busy_q      <= 1'b0;
          load_done_q <= 1'b1;
        end
      end else begin
        byte_idx_q <= byte_idx_q + 9'd1;
      end
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Vector storage: byte k of the active section -> bits [8k+7:8k]
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixels_q   <= '0;
      weights1_q <= '0;
      weights2_q <= '0;
      weights3_q <= '0;
    end else if (byte_ok) begin
      case (state)
        ST_PIX: begin
          for (int unsigned k = 0; k < PIX_N; k++) begin
            if (byte_idx_q == 9'(k)) pixels_q[8*k +: 8] <= bus.data_in;
          end
        end
        ST_W1: begin
          for (int unsigned k = 0; k < W1_N; k++) begin
            if (byte_idx_q == 9'(k)) weights1_q[8*k +: 8] <= bus.data_in;
          end
        end
        ST_W2: begin
          for (int unsigned k = 0; k < W2_N; k++) begin
            if (byte_idx_q == 9'(k)) weights2_q[8*k +: 8] <= bus.data_in;
          end
        end
        ST_W3: begin
          for (int unsigned k = 0; k < W3_N; k++) begin
            if (byte_idx_q == 9'(k)) weights3_q[8*k +: 8] <= bus.data_in;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.pixels    = pixels_q;
  assign bus.weights1  = weights1_q;
  assign bus.weights2  = weights2_q;
  assign bus.weights3  = weights3_q;
  assign bus.load_done = load_done_q;
  assign bus.busy      = busy_q;
  assign bus.byte_idx  = byte_idx_q;
`ifdef BNN_LOADER_CHECKSUM_EN
  assign bus.error     = error_q;
`else
  assign bus.error     = 1'b0;
`endif

endmodule
